// File: rtl/lsu_bus_master_if.sv
// Word-wide, byte-enabled req/ack data bus between the load/store unit and memory.
interface lsu_bus_master_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: turns one core load/store op into one or two aligned,
// byte-enabled bus beats and returns the extended load result.
module lsu_bus_master #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             addr,
    input  logic [31:0]             wr_data,
    input  logic [2:0]              is_load,
    input  logic [1:0]              is_store,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [31:0]             rd_data,
    lsu_bus_master_if.master        mem
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    localparam logic [31:0] TO_LAST = (BUS_TIMEOUT == 0) ? 32'd0 : 32'(BUS_TIMEOUT - 1);

    state_t      state;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [3:0]  be1_q;
    logic [31:0] wdata1_q;
    logic        split_q;
    logic [1:0]  off_q;
    logic [2:0]  bytes_q;
    logic        signed_q;
    logic [31:0] rdata0_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] cnt;

    logic        op_store;
    logic        op_signed;
    logic [2:0]  op_bytes;
    logic [7:0]  op_mask;
    logic [7:0]  op_be;
    logic [63:0] op_wdata;
    logic [23:0] rd_hi;
    logic [55:0] rd_pair;
    logic [31:0] rd_shift;
    logic [31:0] load_result;

    // Decode the op presented by the core into size, signedness and lane placement.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        op_store  = (is_store != 2'b00);
        op_signed = 1'b0;
        op_bytes  = 3'd0;
        if (op_store) begin
            case (is_store)
                2'b01:   op_bytes = 3'd1;
                2'b10:   op_bytes = 3'd2;
                default: op_bytes = 3'd4;
            endcase
        end else begin
            case (is_load)
                3'b001: begin op_bytes = 3'd1; op_signed = 1'b1; end
                3'b010: begin op_bytes = 3'd2; op_signed = 1'b1; end
                3'b011: op_bytes = 3'd4;
                3'b101: op_bytes = 3'd1;
                3'b110: op_bytes = 3'd2;
                default: op_bytes = 3'd0;
            endcase
        end
        case (op_bytes)
            3'd1:    op_mask = 8'h01;
            3'd2:    op_mask = 8'h03;
            3'd4:    op_mask = 8'h0F;
            default: op_mask = 8'h00;
        endcase
        // The upper nibble / upper word are the second beat of a split access.
        op_be    = op_mask << addr[1:0];
        op_wdata = {32'h0, wr_data} << {addr[1:0], 3'b000};
    end

    // Assemble the load result from the captured beat(s) and extend it to 32 bits.
    always_comb begin
        rd_hi   = split_q ? mem.mem_rdata[23:0] : 24'h0;
        rd_pair = split_q ? {rd_hi, rdata0_q} : {rd_hi, mem.mem_rdata};
        case (off_q)
            2'd0:    rd_shift = rd_pair[31:0];
            2'd1:    rd_shift = rd_pair[39:8];
            2'd2:    rd_shift = rd_pair[47:16];
            default: rd_shift = rd_pair[55:24];
        endcase
        case (bytes_q)
            3'd1:    load_result = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                            : {24'h0, rd_shift[7:0]};
            3'd2:    load_result = signed_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                            : {16'h0, rd_shift[15:0]};
            default: load_result = rd_shift;
        endcase
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every branch reads pre-edge values.
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            be1_q       <= 4'h0;
            wdata1_q    <= 32'h0;
            split_q     <= 1'b0;
            off_q       <= 2'd0;
            bytes_q     <= 3'd0;
            signed_q    <= 1'b0;
            rdata0_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_data     <= 32'h0;
            cnt         <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q    <= addr[1:0];
                        bytes_q  <= op_bytes;
                        signed_q <= op_signed;
                        split_q  <= (op_be[7:4] != 4'h0);
                        we_q     <= op_store;
                        addr_q   <= {addr[31:2], 2'b00};
                        be_q     <= op_be[3:0];
                        wdata_q  <= op_wdata[31:0];
                        be1_q    <= op_be[7:4];
                        wdata1_q <= op_wdata[63:32];
                        cnt      <= 32'h0;
                        if (op_bytes == 3'd0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rd_data     <= 32'h0;
                        end else begin
                            state <= BEAT0;
                            req_q <= 1'b1;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (mem.mem_ack) begin
                        cnt <= 32'h0;
                        if (state == BEAT0 && split_q) begin
                            state    <= BEAT1;
                            rdata0_q <= mem.mem_rdata;
                            addr_q   <= addr_q + 32'd4;
                            be_q     <= be1_q;
                            wdata_q  <= wdata1_q;
                        end else begin
                            state       <= RESP;
                            req_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rd_data     <= we_q ? 32'h0 : load_result;
                        end
                    end else if (BUS_TIMEOUT != 0 && cnt == TO_LAST) begin
                        state       <= RESP;
                        req_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rd_data     <= 32'h0;
                        cnt         <= 32'h0;
                    end else if (BUS_TIMEOUT != 0) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are forced low combinationally while reset is asserted.
    assign req_ready     = (state == IDLE) && !rst;
    assign rsp_valid     = rsp_valid_q && !rst;
    assign rsp_err       = rsp_err_q && !rst;
    assign mem.mem_req   = req_q && !rst;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed cases, random ops against a
// byte-level reference model, mid-transaction reset and bus timeouts.
module tb_lsu_bus_master;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [2:0]  is_load;
    logic [1:0]  is_store;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int op_id    = 0;

    lsu_bus_master_if bus ();

    lsu_bus_master #(.BUS_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .wr_data   (wr_data),
        .is_load   (is_load),
        .is_store  (is_store),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rd_data   (rd_data),
        .mem       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL op%0d %s: observed 0x%08h expected 0x%08h", op_id, tag, obs, exp);
        end
    endtask

    // Issue one op and play the memory side; d0/d1 are ack delays per beat.
    task automatic run_op(input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] ld, input logic [1:0] st,
                          input int d0, input int d1,
                          input logic [31:0] rd0, input logic [31:0] rd1);
        int          n;
        bit          sgn;
        bit          is_st;
        int          o;
        bit          split;
        int          nbeats;
        logic [7:0]  be_all;
        logic [63:0] w_all;
        logic [31:0] baddr [2];
        logic [63:0] pair;
        logic [31:0] v;
        logic [31:0] exp_rd;
        bit          timed_out;
        int          d;

        op_id++;
        is_st = (st != 2'b00);
        sgn   = 1'b0;
        n     = 0;
        if (is_st) n = (st == 2'b01) ? 1 : (st == 2'b10) ? 2 : 4;
        else begin
            case (ld)
                3'b001: begin n = 1; sgn = 1'b1; end
                3'b010: begin n = 2; sgn = 1'b1; end
                3'b011: n = 4;
                3'b101: n = 1;
                3'b110: n = 2;
                default: n = 0;
            endcase
        end
        o        = int'(a[1:0]);
        split    = (o + n > 4);
        nbeats   = (n == 0) ? 0 : (split ? 2 : 1);
        be_all   = 8'(((1 << n) - 1) << o);
        w_all    = {32'h0, wd} << (8 * o);
        baddr[0] = a & 32'hFFFF_FFFC;
        baddr[1] = baddr[0] + 32'd4;

        req_valid = 1'b1;
        addr      = a;
        wr_data   = wd;
        is_load   = ld;
        is_store  = st;
        #1;
        check("req_ready idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        addr      = $urandom;
        wr_data   = $urandom;
        is_load   = 3'($urandom);
        is_store  = 2'($urandom);

        timed_out = 1'b0;
        for (int b = 0; b < nbeats && !timed_out; b++) begin
            d = (b == 0) ? d0 : d1;
            for (int c = 0; c < TO; c++) begin
                check("mem_req", 32'(bus.mem_req), 32'd1);
                check("req_ready busy", 32'(req_ready), 32'd0);
                check("mem_addr", bus.mem_addr, baddr[b]);
                check("mem_be", 32'(bus.mem_be), 32'(b == 0 ? be_all[3:0] : be_all[7:4]));
                check("mem_we", 32'(bus.mem_we), 32'(is_st));
                if (is_st) check("mem_wdata", bus.mem_wdata, b == 0 ? w_all[31:0] : w_all[63:32]);
                if (c == d) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = (b == 0) ? rd0 : rd1;
                    @(negedge clk);
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    break;
                end
                @(negedge clk);
                if (c == TO - 1) timed_out = 1'b1;
            end
        end

        pair = {split ? rd1 : 32'h0, rd0} >> (8 * o);
        v    = pair[31:0];
        if (n == 1) v = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
        if (n == 2) v = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
        exp_rd = (timed_out || is_st || n == 0) ? 32'h0 : v;

        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(timed_out));
        check("rd_data", rd_data, exp_rd);
        check("mem_req in resp", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        check("rsp_valid pulse", 32'(rsp_valid), 32'd0);
        check("rd_data hold", rd_data, exp_rd);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rl;
        logic [1:0]  rs;

        rst           = 1'b1;
        req_valid     = 1'b0;
        addr          = 32'h0;
        wr_data       = 32'h0;
        is_load       = 3'b000;
        is_store      = 2'b00;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst mem_req", 32'(bus.mem_req), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst req_ready", 32'(req_ready), 32'd1);
        check("post-rst rd_data", rd_data, 32'h0);
        check("post-rst mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);

        // Directed cases.
        run_op(32'h0000_0100, 32'h0, 3'b011, 2'b00, 0, 0, 32'hDEAD_BEEF, 32'h0);
        run_op(32'h0000_0103, 32'h0, 3'b001, 2'b00, 0, 0, 32'h8011_2233, 32'h0);
        run_op(32'h0000_0103, 32'h0, 3'b101, 2'b00, 1, 0, 32'h8011_2233, 32'h0);
        run_op(32'h0000_0102, 32'h0000_1234, 3'b000, 2'b10, 0, 0, 32'h0, 32'h0);
        run_op(32'h0000_0105, 32'hAABB_CCDD, 3'b000, 2'b11, 0, 2, 32'h0, 32'h0);
        run_op(32'hFFFF_FFFF, 32'h0, 3'b110, 2'b00, 0, 0, 32'h3400_0000, 32'h0000_0012);
        run_op(32'h0000_0102, 32'h0, 3'b010, 2'b00, 0, 0, 32'h8765_4321, 32'h0);
        run_op(32'h0000_0040, 32'h0, 3'b000, 2'b00, 0, 0, 32'h0, 32'h0);
        run_op(32'h0000_0040, 32'h0, 3'b111, 2'b00, 0, 0, 32'h0, 32'h0);
        run_op(32'h0000_0300, 32'h0, 3'b011, 2'b00, 99, 0, 32'h1111_1111, 32'h0);
        run_op(32'h0000_0105, 32'hAABB_CCDD, 3'b000, 2'b11, 0, 99, 32'h0, 32'h0);

        // Random ops; ack delays >= TO exercise the timeout.
        for (int i = 0; i < 250; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            rl = 3'($urandom);
            rs = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            run_op(ra, $urandom, rl, rs,
                   ($urandom_range(0, 5) == 5) ? 5 : $urandom_range(0, 3),
                   ($urandom_range(0, 5) == 5) ? 5 : $urandom_range(0, 3),
                   $urandom, $urandom);
        end

        // Reset in the middle of BEAT0 while the memory is still stalling.
        run_op(32'h0000_0100, 32'h0, 3'b011, 2'b00, 0, 0, 32'hDEAD_BEEF, 32'h0);
        op_id++;
        req_valid = 1'b1;
        addr      = 32'h0000_0200;
        is_load   = 3'b011;
        is_store  = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst-test beat0 req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        #1;
        check("rst-cycle mem_req", 32'(bus.mem_req), 32'd0);
        check("rst-cycle req_ready", 32'(req_ready), 32'd0);
        check("rst-cycle rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        check("after-rst req_ready", 32'(req_ready), 32'd1);
        check("after-rst rd_data", rd_data, 32'h0);
        for (int c = 0; c < 6; c++) begin
            check("after-rst no rsp", 32'(rsp_valid), 32'd0);
            check("after-rst no req", 32'(bus.mem_req), 32'd0);
            @(negedge clk);
        end
        run_op(32'h0000_0104, 32'h0, 3'b101, 2'b00, 0, 0, 32'h0000_00F0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
